// File: rtl/rain_pkg.sv
// Shared types and constants for the rain-sensor debouncer.
// Holds the debouncer state encoding and the event-counter width/limit.
package rain_pkg;

  typedef enum logic [1:0] {
    DRY      = 2'd0,
    WET_PEND = 2'd1,
    WET      = 2'd2,
    DRY_PEND = 2'd3
  } rain_state_t;

  localparam int          RAIN_EVT_W   = 16;
  localparam logic [15:0] RAIN_EVT_MAX = 16'hFFFF;

endpackage

// File: rtl/rain_sync.sv
// N-flop single-bit synchroniser for an asynchronous input.
// Ports: clk, rst (async, active-high), d (async in), q (synchronised out).
module rain_sync #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [N-1:0] r_ff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_ff <= '0;
    else     r_ff <= {r_ff[N-2:0], d};
  end

  assign q = r_ff[N-1];

endmodule

// File: rtl/rain_debouncer.sv
// Rain-sensor debouncer: synchronise, qualify wet/dry windows, emit pulses.
// Ports: clk, rst (async, active-high), raw_rain (async in), rain_sensor,
// rain_onset, rain_clear (registered), rain_events (16-bit onset count).
// Macro RAIN_EVENT_COUNT_EN enables the saturating onset counter;
// without it rain_events is tied to zero.
module rain_debouncer
  import rain_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int WET_CYCLES  = 16,
  parameter int DRY_CYCLES  = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        raw_rain,
  output logic        rain_sensor,
  output logic        rain_onset,
  output logic        rain_clear,
  output logic [15:0] rain_events
);

  localparam int MAXC = (WET_CYCLES > DRY_CYCLES) ? WET_CYCLES : DRY_CYCLES;
  localparam int CW   = $clog2(MAXC) + 1;

  logic          w_s;
  rain_state_t   r_state;
  rain_state_t   w_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic          r_sensor;
  logic          r_onset;
  logic          r_clear;

  rain_sync #(.N(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (raw_rain),
    .q   (w_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= DRY;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // The counter is cleared on every state change so it never wraps.
  always_comb begin
    w_next     = r_state;
    w_cnt_next = '0;
    unique case (r_state)
      DRY: begin
        if (w_s) w_next = WET_PEND;
      end
      WET_PEND: begin
        if (!w_s)
          w_next = DRY;
        else if (r_cnt == CW'(WET_CYCLES - 1))
          w_next = WET;
        else
          w_cnt_next = r_cnt + 1'b1;
      end
      WET: begin
        if (!w_s) w_next = DRY_PEND;
      end
      DRY_PEND: begin
        if (w_s)
          w_next = WET;
        else if (r_cnt == CW'(DRY_CYCLES - 1))
          w_next = DRY;
        else
          w_cnt_next = r_cnt + 1'b1;
      end
      default: w_next = DRY;
    endcase
  end

  // Outputs are registered from the next state so they change on the
  // same edge as the qualifying transition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sensor <= 1'b0;
      r_onset  <= 1'b0;
      r_clear  <= 1'b0;
    end else begin
      r_sensor <= (w_next == WET) || (w_next == DRY_PEND);
      r_onset  <= (r_state == WET_PEND) && (w_next == WET);
      r_clear  <= (r_state == DRY_PEND) && (w_next == DRY);
    end
  end

  assign rain_sensor = r_sensor;
  assign rain_onset  = r_onset;
  assign rain_clear  = r_clear;

`ifdef RAIN_EVENT_COUNT_EN
  logic [RAIN_EVT_W-1:0] r_events;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_events <= '0;
    else if (r_onset && (r_events != RAIN_EVT_MAX))
      r_events <= r_events + 1'b1;
  end

  assign rain_events = r_events;
`else
  assign rain_events = 16'h0000;
`endif

endmodule

// File: tb/tb_rain_debouncer.sv
// Directed self-checking bench for rain_debouncer (default parameters).
// Edge k is the k-th rising clk edge after raw_rain last changed.
module tb_rain_debouncer;
  import rain_pkg::*;

  logic        clk;
  logic        rst;
  logic        raw_rain;
  logic        rain_sensor;
  logic        rain_onset;
  logic        rain_clear;
  logic [15:0] rain_events;

  int n_chk;
  int n_err;

  rain_debouncer dut (
    .clk         (clk),
    .rst         (rst),
    .raw_rain    (raw_rain),
    .rain_sensor (rain_sensor),
    .rain_onset  (rain_onset),
    .rain_clear  (rain_clear),
    .rain_events (rain_events)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_dry();
    raw_rain = 1'b0;
    for (int k = 1; k <= 70; k++) tick();
    chk("dry_settle", rain_sensor, 1'b0);
  endtask

  logic g_raw;
  int   n_onsets;

  initial begin
    n_chk    = 0;
    n_err    = 0;
    n_onsets = 0;
    rst      = 1'b1;
    raw_rain = 1'b0;
    repeat (3) tick();
    chk("rst_sensor", rain_sensor, 1'b0);
    chk("rst_onset", rain_onset, 1'b0);
    chk("rst_clear", rain_clear, 1'b0);
    chk("rst_events", rain_events, 16'h0);
    chk("rst_state", dut.r_state, DRY);
    rst = 1'b0;
    tick();

    // Clean wet qualification: rises on edge 19.
    raw_rain = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk("wet_sensor", rain_sensor, (k >= 19));
      chk("wet_onset", rain_onset, (k == 19));
      chk("wet_clear", rain_clear, 1'b0);
    end
    n_onsets++;

    // Clean dry qualification: falls on edge 67.
    raw_rain = 1'b0;
    for (int k = 1; k <= 68; k++) begin
      tick();
      chk("dry_sensor", rain_sensor, (k < 67));
      chk("dry_clear", rain_clear, (k == 67));
      chk("dry_onset", rain_onset, 1'b0);
    end

    // 10 high, 1 low, then high: restart, onset at edge 30.
    for (int k = 1; k <= 31; k++) begin
      g_raw    = (k != 11);
      raw_rain = g_raw;
      tick();
      chk("glw_onset", rain_onset, (k == 30));
      chk("glw_sensor", rain_sensor, (k >= 30));
    end
    n_onsets++;

    // One-cycle dry glitch while WET must be absorbed.
    for (int k = 1; k <= 10; k++) begin
      raw_rain = (k != 1);
      tick();
      chk("gld_sensor", rain_sensor, 1'b1);
      chk("gld_clear", rain_clear, 1'b0);
    end
    chk("gld_state", dut.r_state, WET);

    // Async reset during WET_PEND at cnt=10.
    go_dry();
    raw_rain = 1'b1;
    for (int k = 1; k <= 13; k++) tick();
    chk("pre_rst_state", dut.r_state, WET_PEND);
    chk("pre_rst_cnt", dut.r_cnt, 10);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_state", dut.r_state, DRY);
    chk("arst_cnt", dut.r_cnt, 0);
    chk("arst_sensor", rain_sensor, 1'b0);
    chk("arst_onset", rain_onset, 1'b0);
    chk("arst_clear", rain_clear, 1'b0);
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk("rq_sensor", rain_sensor, (k >= 19));
      chk("rq_onset", rain_onset, (k == 19));
    end
    n_onsets++;

`ifdef RAIN_EVENT_COUNT_EN
    chk("evt_count", rain_events, n_onsets);
    go_dry();
    force dut.r_events = 16'hFFFE;
    tick();
    release dut.r_events;
    for (int r = 0; r < 2; r++) begin
      raw_rain = 1'b1;
      for (int k = 1; k <= 20; k++) tick();
      go_dry();
    end
    chk("evt_sat", rain_events, 16'hFFFF);
`else
    chk("evt_off", rain_events, 16'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
